mux_sel_sequencer: RTL and testbench



---
 rtl/mux_sel_sequencer.sv | 123 ++++++++++++
 tb/tb_mux_sel_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a 4-to-1 mux: one bounded grant at a time,
// with a single dead cycle between grants so the mux output never switches mid-transfer.
module mux_sel_sequencer #(
   parameter int HOLD_MAX = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_req,
   input  logic       i_done,
   output logic       o_s1,
   output logic       o_s0,
   output logic [3:0] o_gnt,
   output logic       o_valid
);

   localparam int CW = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_ptr;
   logic [1:0]    w_ptr_nxt;
   logic [1:0]    r_sel;
   logic [1:0]    w_sel_nxt;
   logic [1:0]    w_winner;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [3:0]    r_gnt;
   logic [3:0]    w_gnt_nxt;
   logic          r_valid;
   logic          w_valid_nxt;
   logic          w_release;

   // Search order is ptr+1, ptr+2, ptr+3, ptr; iterating downwards lets the nearest hit win.
   function automatic logic [1:0] f_winner(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] win;
      win = ptr;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            win = idx;
         end
      end
      return win;
   endfunction

   assign o_s1    = r_sel[1];
   assign o_s0    = r_sel[0];
   assign o_gnt   = r_gnt;
   assign o_valid = r_valid;

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = r_gnt;
      w_valid_nxt = r_valid;
      w_winner    = f_winner(i_req, r_ptr);
      w_release   = i_done || !i_req[r_sel] || (r_cnt == CW'(HOLD_MAX));

      case (r_state)
         ST_GRANT: begin
            if (w_release) begin
               w_state_nxt = ST_GAP;
               w_valid_nxt = 1'b0;
               w_gnt_nxt   = 4'b0000;
               w_cnt_nxt   = CW'(0);
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         ST_IDLE, ST_GAP: begin
            if (|i_req) begin
               w_state_nxt = ST_GRANT;
               w_sel_nxt   = w_winner;
               w_ptr_nxt   = w_winner;
               w_gnt_nxt   = 4'b0001 << w_winner;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = CW'(1);
            end else begin
               w_state_nxt = ST_IDLE;
               w_valid_nxt = 1'b0;
               w_gnt_nxt   = 4'b0000;
               w_cnt_nxt   = CW'(0);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_gnt_nxt   = 4'b0000;
            w_cnt_nxt   = CW'(0);
         end
      endcase
   end

   // State and output registers; ptr resets to 3 so the first search begins at channel 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= 2'd3;
         r_sel   <= 2'd0;
         r_cnt   <= CW'(0);
         r_gnt   <= 4'b0000;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
         r_valid <= w_valid_nxt;
      end
   end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: behavioural grant model compared every cycle,
// plus hand-computed expectations for each scenario.
module tb_mux_sel_sequencer;

   localparam int HOLD = 4;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic [3:0] i_req = 4'b0000;
   logic       i_done = 1'b0;
   logic       o_s1;
   logic       o_s0;
   logic [3:0] o_gnt;
   logic       o_valid;

   int n_vec  = 0;
   int n_miss = 0;

   mux_sel_sequencer #(.HOLD_MAX(HOLD)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (i_req),
      .i_done  (i_done),
      .o_s1    (o_s1),
      .o_s0    (o_s0),
      .o_gnt   (o_gnt),
      .o_valid (o_valid)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [1:0] s, input logic [3:0] g);
      chk({name, "_valid"}, {3'b000, o_valid}, {3'b000, v});
      chk({name, "_sel"}, {2'b00, o_s1, o_s0}, {2'b00, s});
      chk({name, "_gnt"}, o_gnt, g);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Behavioural model: busy flag, granted channel, cycles held, last winner.
   int m_state = 0;   // 0 idle, 1 granted, 2 dead cycle
   int m_ch    = 0;
   int m_age   = 0;
   int m_last  = 3;

   function automatic int pick(input logic [3:0] req, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (req[(last + k) % 4]) return (last + k) % 4;
      end
      return last;
   endfunction

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_state <= 0;
         m_ch    <= 0;
         m_age   <= 0;
         m_last  <= 3;
      end else if (m_state == 1) begin
         if (i_done || !i_req[m_ch] || m_age == HOLD) m_state <= 2;
         else m_age <= m_age + 1;
      end else if (i_req != 4'b0000) begin
         m_ch    <= pick(i_req, m_last);
         m_last  <= pick(i_req, m_last);
         m_age   <= 1;
         m_state <= 1;
      end else begin
         m_state <= 0;
      end
   end

   logic       prev_valid = 1'b0;
   logic [1:0] prev_sel   = 2'b00;

   always @(negedge i_clk) begin
      chk("mdl_valid", {3'b000, o_valid}, {3'b000, (m_state == 1)});
      chk("mdl_sel", {2'b00, o_s1, o_s0}, 4'(m_ch));
      chk("mdl_gnt", o_gnt, (m_state == 1) ? (4'b0001 << m_ch) : 4'b0000);
      if (o_valid) chk("gnt_onehot", o_gnt, 4'b0001 << {o_s1, o_s0});
      if (prev_valid && o_valid) chk("sel_stable", {2'b00, o_s1, o_s0}, {2'b00, prev_sel});
      prev_valid = o_valid;
      prev_sel   = {o_s1, o_s0};
   end

   initial begin
      logic       ev;
      logic [1:0] es;
      #1 i_rst = 1'b1;
      repeat (2) tick();
      chk_out("rst", 1'b0, 2'b00, 4'b0000);
      i_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out("idle", 1'b0, 2'b00, 4'b0000);
      end

      // Round robin 0,1,2,3,0 with one dead cycle after each grant.
      i_req = 4'b1111;
      for (int k = 1; k <= 25; k++) begin
         tick();
         ev = ((k % 5) != 0);
         es = 2'(((k - 1) / 5) % 4);
         chk_out("rr", ev, es, ev ? (4'b0001 << es) : 4'b0000);
      end
      i_req = 4'b0000;
      tick();
      chk_out("rr_idle", 1'b0, 2'b00, 4'b0000);

      // Lone channel 2 repeatedly times out and is regranted.
      i_req = 4'b0100;
      for (int k = 1; k <= 10; k++) begin
         tick();
         ev = ((k % 5) != 0);
         chk_out("tmo", ev, 2'b10, ev ? 4'b0100 : 4'b0000);
      end
      i_req = 4'b0000;
      tick();
      chk_out("tmo_idle", 1'b0, 2'b10, 4'b0000);

      // Early release of channel 1 in its second cycle.
      i_req = 4'b0010;
      tick();
      chk_out("er_g1", 1'b1, 2'b01, 4'b0010);
      tick();
      chk_out("er_g2", 1'b1, 2'b01, 4'b0010);
      i_done = 1'b1;
      i_req  = 4'b0011;
      tick();
      chk_out("er_rel", 1'b0, 2'b01, 4'b0000);
      i_done = 1'b0;
      tick();
      chk_out("er_next", 1'b1, 2'b00, 4'b0001);

      // Request drop: channel 0 then channel 3 lose their request.
      i_req = 4'b1000;
      tick();
      chk_out("rd_rel0", 1'b0, 2'b00, 4'b0000);
      tick();
      chk_out("rd_g3", 1'b1, 2'b11, 4'b1000);
      i_req = 4'b0000;
      tick();
      chk_out("rd_rel", 1'b0, 2'b11, 4'b0000);
      tick();
      chk_out("rd_idle", 1'b0, 2'b11, 4'b0000);

      // done coincides with timeout; timed-out channel 2 loses to channel 3.
      i_req = 4'b0100;
      tick();
      chk_out("dt_g", 1'b1, 2'b10, 4'b0100);
      repeat (3) tick();
      chk_out("dt_hold", 1'b1, 2'b10, 4'b0100);
      i_done = 1'b1;
      i_req  = 4'b1100;
      tick();
      chk_out("dt_rel", 1'b0, 2'b10, 4'b0000);
      i_done = 1'b0;
      tick();
      chk_out("dt_next", 1'b1, 2'b11, 4'b1000);

      // Asynchronous reset in the middle of a channel 2 grant.
      i_req = 4'b0100;
      tick();
      chk_out("rs_gap", 1'b0, 2'b11, 4'b0000);
      tick();
      chk_out("rs_g2", 1'b1, 2'b10, 4'b0100);
      #2;
      i_rst = 1'b1;
      i_req = 4'b0000;
      #1;
      chk_out("rs_async", 1'b0, 2'b00, 4'b0000);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out("rs_idle", 1'b0, 2'b00, 4'b0000);
      end
      i_req = 4'b1001;
      tick();
      chk_out("rs_first", 1'b1, 2'b00, 4'b0001);
      i_req = 4'b0000;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
